// File: rtl/spi_rx_pack.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// spi_rx_pack : packs 1..4 SPI RX bytes into a right-justified 32-bit word
//               behind a valid/ready hold register.
//               Define SPI_RX_TIMEOUT_EN to abort stalled collects.
// Revision    : 1.0
// ============================================================================
module spi_rx_pack #(
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [1:0]  nbytes,
   input  logic        rx_dv,
   input  logic [7:0]  rx_byte,
   output logic [31:0] dout,
   output logic        valid,
   input  logic        ready,
   output logic        busy,
   output logic        overflow,
   output logic        timeout
);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_COLLECT = 2'd1,
      ST_HOLD    = 2'd2
   } state_t;

   state_t      state_q, state_d;
   logic [31:0] shift_q, shift_d;
   logic [31:0] dout_q, dout_d;
   logic [1:0]  cnt_q, cnt_d;
   logic [1:0]  target_q, target_d;
   logic        valid_q, valid_d;
   logic        overflow_q, overflow_d;
   logic        timeout_q;

   logic [31:0] w_shift_next;
   logic [31:0] w_byte_mask;
   logic        w_last;
   logic        w_start_acc;
   logic        w_abort;

   assign w_shift_next = {shift_q[23:0], rx_byte};
   assign w_last       = (cnt_q == target_q);
   // A start is only honoured when the packer is free or hands off its word.
   assign w_start_acc  = start && ((state_q == ST_IDLE) ||
                                   ((state_q == ST_HOLD) && ready));

   always_comb begin
      w_byte_mask = 32'hFFFF_FFFF;
      case (target_q)
         2'd0:    w_byte_mask = 32'h0000_00FF;
         2'd1:    w_byte_mask = 32'h0000_FFFF;
         2'd2:    w_byte_mask = 32'h00FF_FFFF;
         default: w_byte_mask = 32'hFFFF_FFFF;
      endcase
   end

`ifdef SPI_RX_TIMEOUT_EN
   localparam logic [15:0] C_IDLE_LAST = 16'(TIMEOUT_CYCLES - 2);

   logic [15:0] idle_cnt_q, idle_cnt_d;
   logic        timeout_d;

   // Abort on the edge where the idle count would reach TIMEOUT_CYCLES-1.
   assign w_abort = (state_q == ST_COLLECT) && !rx_dv && (idle_cnt_q == C_IDLE_LAST);

   always_comb begin
      idle_cnt_d = idle_cnt_q;
      timeout_d  = 1'b0;
      if (w_start_acc) begin
         idle_cnt_d = 16'd0;
      end else if (state_q == ST_COLLECT) begin
         if (rx_dv) begin
            idle_cnt_d = 16'd0;
         end else if (w_abort) begin
            idle_cnt_d = 16'd0;
            timeout_d  = 1'b1;
         end else begin
            idle_cnt_d = idle_cnt_q + 16'd1;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         idle_cnt_q <= 16'd0;
         timeout_q  <= 1'b0;
      end else begin
         idle_cnt_q <= idle_cnt_d;
         timeout_q  <= timeout_d;
      end
   end
`else
   logic unused_timeout_cfg;

   assign unused_timeout_cfg = ^(16'(TIMEOUT_CYCLES));
   assign w_abort            = 1'b0;
   assign timeout_q          = 1'b0;
`endif

   always_comb begin
      state_d    = state_q;
      shift_d    = shift_q;
      cnt_d      = cnt_q;
      target_d   = target_q;
      dout_d     = dout_q;
      valid_d    = valid_q;
      overflow_d = overflow_q;

      case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d    = ST_COLLECT;
               target_d   = nbytes;
               shift_d    = 32'd0;
               cnt_d      = 2'd0;
               overflow_d = 1'b0;
            end
         end

         ST_COLLECT: begin
            if (rx_dv) begin
               shift_d = w_shift_next;
               cnt_d   = cnt_q + 2'd1;
               if (w_last) begin
                  dout_d  = w_shift_next & w_byte_mask;
                  valid_d = 1'b1;
                  state_d = ST_HOLD;
               end
            end else if (w_abort) begin
               state_d = ST_IDLE;
               shift_d = 32'd0;
               cnt_d   = 2'd0;
            end
         end

         ST_HOLD: begin
            if (ready) begin
               valid_d = 1'b0;
               state_d = ST_IDLE;
               if (start) begin
                  state_d    = ST_COLLECT;
                  target_d   = nbytes;
                  shift_d    = 32'd0;
                  cnt_d      = 2'd0;
                  overflow_d = 1'b0;
               end
            end
         end

         default: begin
            state_d = ST_IDLE;
            valid_d = 1'b0;
         end
      endcase

      // A byte arriving outside COLLECT is dropped; flagging wins over a start's clear.
      if (rx_dv && (state_q != ST_COLLECT)) begin
         overflow_d = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= ST_IDLE;
         shift_q    <= 32'd0;
         dout_q     <= 32'd0;
         cnt_q      <= 2'd0;
         target_q   <= 2'd0;
         valid_q    <= 1'b0;
         overflow_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         shift_q    <= shift_d;
         dout_q     <= dout_d;
         cnt_q      <= cnt_d;
         target_q   <= target_d;
         valid_q    <= valid_d;
         overflow_q <= overflow_d;
      end
   end

   assign dout     = dout_q;
   assign valid    = valid_q;
   assign busy     = (state_q != ST_IDLE);
   assign overflow = overflow_q;
   assign timeout  = timeout_q;

endmodule
`default_nettype wire

// File: tb/tb_spi_rx_pack.sv
`timescale 1ns/1ps
`default_nettype none
// Self-checking bench for spi_rx_pack: directed scenarios plus randomized
// reads compared against a positional byte-weight model.
module tb_spi_rx_pack;

   logic        clk = 1'b0;
   logic        reset, start, rx_dv, ready;
   logic [1:0]  nbytes;
   logic [7:0]  rx_byte;
   logic [31:0] dout;
   logic        valid, busy, overflow, timeout;

   int          total = 0;
   int          bad   = 0;
   logic [31:0] held_word = 32'd0;

   spi_rx_pack #(.TIMEOUT_CYCLES(8)) dut (
      .clk      (clk),
      .reset    (reset),
      .start    (start),
      .nbytes   (nbytes),
      .rx_dv    (rx_dv),
      .rx_byte  (rx_byte),
      .dout     (dout),
      .valid    (valid),
      .ready    (ready),
      .busy     (busy),
      .overflow (overflow),
      .timeout  (timeout)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   // First byte is most significant; each byte weighted by its distance from the last.
   function automatic logic [31:0] model_word(input logic [7:0] b [4], input int n);
      logic [31:0] w;
      w = 32'd0;
      for (int i = 0; i < n; i++)
         w = w + (32'(b[i]) * (32'd1 << (8 * (n - 1 - i))));
      return w;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_byte(input logic [7:0] b);
      rx_dv   = 1'b1;
      rx_byte = b;
      tick();
      rx_dv   = 1'b0;
      rx_byte = 8'h00;
   endtask

   task automatic test_reset();
      reset = 1'b1; start = 1'b0; rx_dv = 1'b0; rx_byte = 8'h00;
      ready = 1'b0; nbytes = 2'd0;
      repeat (3) tick();
      total++;
      if ({dout, valid, busy, overflow, timeout} !== 36'h0) begin
         bad++;
         $display("FAIL reset_outputs got=%h exp=0", {dout, valid, busy, overflow, timeout});
      end
      reset = 1'b0;
      tick();
      total++;
      if ({dout, valid, busy, overflow, timeout} !== 36'h0) begin
         bad++;
         $display("FAIL post_reset_idle got=%h exp=0", {dout, valid, busy, overflow, timeout});
      end
   endtask

   task automatic test_four_byte();
      logic [7:0]  b [4];
      logic [31:0] exp;
      b[0] = 8'hDE; b[1] = 8'hAD; b[2] = 8'hBE; b[3] = 8'hEF;
      exp = model_word(b, 4);
      ready = 1'b1; start = 1'b1; nbytes = 2'd3;
      tick();
      start = 1'b0;
      total++;
      if (busy !== 1'b1) begin
         bad++; $display("FAIL fb_busy got=%b exp=1", busy);
      end
      for (int i = 0; i < 4; i++) begin
         repeat (4) tick();
         send_byte(b[i]);
         if (i < 3) begin
            total++;
            if (valid !== 1'b0) begin
               bad++; $display("FAIL fb_early_valid byte=%0d got=%b exp=0", i, valid);
            end
         end
      end
      total++;
      if ({valid, dout} !== {1'b1, exp}) begin
         bad++; $display("FAIL fb_word got=%b/%h exp=1/%h", valid, dout, exp);
      end
      held_word = exp;
      tick();
      total++;
      if ({valid, busy} !== 2'b00) begin
         bad++; $display("FAIL fb_release valid/busy got=%b exp=00", {valid, busy});
      end
      ready = 1'b0;
   endtask

   task automatic test_hold_word();
      logic [7:0]  b [4];
      logic [31:0] exp;
      b[0] = 8'h12; b[1] = 8'h34; b[2] = 8'h00; b[3] = 8'h00;
      exp = model_word(b, 2);
      ready = 1'b0; start = 1'b1; nbytes = 2'd1;
      tick();
      start = 1'b0;
      send_byte(b[0]);
      tick();
      send_byte(b[1]);
      for (int k = 0; k < 10; k++) begin
         total++;
         if ({valid, dout} !== {1'b1, exp}) begin
            bad++; $display("FAIL hw_held cyc=%0d got=%b/%h exp=1/%h", k, valid, dout, exp);
         end
         tick();
      end
      ready = 1'b1;
      tick();
      ready = 1'b0;
      total++;
      if ({valid, busy, overflow} !== 3'b000) begin
         bad++; $display("FAIL hw_transfer got=%b exp=000", {valid, busy, overflow});
      end
      tick();
      total++;
      if ({valid, dout} !== {1'b0, exp}) begin
         bad++; $display("FAIL hw_single_transfer got=%b/%h exp=0/%h", valid, dout, exp);
      end
      held_word = exp;
   endtask

   task automatic test_overflow();
      ready = 1'b0; start = 1'b1; nbytes = 2'd0;
      tick();
      start = 1'b0;
      send_byte(8'h3C);
      send_byte(8'h55);
      total++;
      if ({valid, overflow, dout} !== {2'b11, 32'h0000_003C}) begin
         bad++; $display("FAIL ov_hold_byte got=%b%b/%h exp=11/0000003c", valid, overflow, dout);
      end
      ready = 1'b1;
      tick();
      ready = 1'b0;
      total++;
      if ({valid, busy, overflow} !== 3'b001) begin
         bad++; $display("FAIL ov_sticky got=%b exp=001", {valid, busy, overflow});
      end
      start = 1'b1; nbytes = 2'd1; rx_dv = 1'b1; rx_byte = 8'hEE;
      tick();
      start = 1'b0; rx_dv = 1'b0; rx_byte = 8'h00;
      total++;
      if ({busy, overflow} !== 2'b11) begin
         bad++; $display("FAIL ov_idle_dv_with_start got=%b exp=11", {busy, overflow});
      end
      send_byte(8'h01);
      send_byte(8'h02);
      total++;
      if ({valid, dout} !== {1'b1, 32'h0000_0102}) begin
         bad++; $display("FAIL ov_dropped_byte got=%b/%h exp=1/00000102", valid, dout);
      end
      ready = 1'b1; start = 1'b1; nbytes = 2'd0;
      tick();
      start = 1'b0;
      total++;
      if ({busy, overflow} !== 2'b10) begin
         bad++; $display("FAIL ov_cleared_by_start got=%b exp=10", {busy, overflow});
      end
      send_byte(8'h44);
      total++;
      if ({valid, dout} !== {1'b1, 32'h0000_0044}) begin
         bad++; $display("FAIL ov_next_word got=%b/%h exp=1/00000044", valid, dout);
      end
      tick();
      ready = 1'b0;
      held_word = 32'h0000_0044;
   endtask

   task automatic test_back_to_back();
      ready = 1'b0; start = 1'b1; nbytes = 2'd1;
      tick();
      start = 1'b0;
      send_byte(8'hAB);
      send_byte(8'hCD);
      total++;
      if ({valid, dout} !== {1'b1, 32'h0000_ABCD}) begin
         bad++; $display("FAIL b2b_first got=%b/%h exp=1/0000abcd", valid, dout);
      end
      ready = 1'b1; start = 1'b1; nbytes = 2'd0;
      tick();
      ready = 1'b0; start = 1'b0;
      total++;
      if ({valid, busy} !== 2'b01) begin
         bad++; $display("FAIL b2b_no_idle valid/busy got=%b exp=01", {valid, busy});
      end
      send_byte(8'hA5);
      total++;
      if ({valid, dout} !== {1'b1, 32'h0000_00A5}) begin
         bad++; $display("FAIL b2b_second got=%b/%h exp=1/000000a5", valid, dout);
      end
      ready = 1'b1;
      tick();
      ready = 1'b0;
      total++;
      if (busy !== 1'b0) begin
         bad++; $display("FAIL b2b_done busy got=%b exp=0", busy);
      end
      held_word = 32'h0000_00A5;
   endtask

   task automatic test_timeout();
      start = 1'b1; nbytes = 2'd2;
      tick();
      start = 1'b0;
      send_byte(8'h77);
`ifdef SPI_RX_TIMEOUT_EN
      for (int k = 1; k <= 7; k++) begin
         tick();
         total++;
         if (k < 7) begin
            if ({timeout, busy, valid} !== 3'b010) begin
               bad++; $display("FAIL to_wait k=%0d got=%b exp=010", k, {timeout, busy, valid});
            end
         end else begin
            if ({timeout, busy, valid, dout} !== {3'b100, held_word}) begin
               bad++; $display("FAIL to_pulse got=%b/%h exp=100/%h", {timeout, busy, valid}, dout, held_word);
            end
         end
      end
      tick();
      total++;
      if ({timeout, busy, valid} !== 3'b000) begin
         bad++; $display("FAIL to_one_cycle got=%b exp=000", {timeout, busy, valid});
      end
`else
      repeat (12) tick();
      total++;
      if ({busy, timeout, valid} !== 3'b100) begin
         bad++; $display("FAIL to_waits got=%b exp=100", {busy, timeout, valid});
      end
      reset = 1'b1;
      tick();
      reset = 1'b0;
      tick();
`endif
   endtask

   task automatic test_reset_mid();
      ready = 1'b1; start = 1'b1; nbytes = 2'd0;
      tick();
      start = 1'b0;
      send_byte(8'h99);
      tick();
      total++;
      if ({valid, dout} !== {1'b0, 32'h0000_0099}) begin
         bad++; $display("FAIL rm_pre got=%b/%h exp=0/00000099", valid, dout);
      end
      start = 1'b1; nbytes = 2'd3;
      tick();
      start = 1'b0;
      send_byte(8'h01);
      send_byte(8'h02);
      #2 reset = 1'b1;
      #1;
      total++;
      if ({dout, valid, busy, overflow, timeout} !== 36'h0) begin
         bad++; $display("FAIL rm_async got=%h exp=0", {dout, valid, busy, overflow, timeout});
      end
      tick();
      reset = 1'b0;
      tick();
      start = 1'b1; nbytes = 2'd0;
      tick();
      start = 1'b0;
      send_byte(8'h7F);
      total++;
      if ({valid, dout} !== {1'b1, 32'h0000_007F}) begin
         bad++; $display("FAIL rm_new_read got=%b/%h exp=1/0000007f", valid, dout);
      end
      tick();
      ready = 1'b0;
   endtask

   task automatic test_random();
      logic [7:0]  b [4];
      logic [31:0] exp;
      int          n;
      for (int it = 0; it < 40; it++) begin
         n = int'($urandom_range(1, 4));
         for (int i = 0; i < 4; i++) b[i] = 8'($urandom_range(0, 255));
         exp = model_word(b, n);
         ready = 1'b0; start = 1'b1; nbytes = 2'(n - 1);
         tick();
         start = 1'b0;
         for (int i = 0; i < n; i++) begin
            repeat ($urandom_range(0, 3)) tick();
            total++;
            if ({valid, busy} !== 2'b01) begin
               bad++; $display("FAIL rnd_collect it=%0d byte=%0d got=%b exp=01", it, i, {valid, busy});
            end
            send_byte(b[i]);
         end
         repeat ($urandom_range(0, 3)) tick();
         total++;
         if ({valid, overflow, dout} !== {2'b10, exp}) begin
            bad++; $display("FAIL rnd_word it=%0d n=%0d got=%b%b/%h exp=10/%h", it, n, valid, overflow, dout, exp);
         end
         ready = 1'b1;
         tick();
         ready = 1'b0;
         total++;
         if ({valid, busy, dout} !== {2'b00, exp}) begin
            bad++; $display("FAIL rnd_release it=%0d got=%b/%h exp=00/%h", it, {valid, busy}, dout, exp);
         end
      end
   endtask

   initial begin
      test_reset();
      test_four_byte();
      test_hold_word();
      test_overflow();
      test_back_to_back();
      test_timeout();
      test_reset_mid();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
